// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline control blocks.
package mips_pkg;

  localparam int          NREG_DEF = 32;
  localparam logic [31:0] R0_MASK  = ~32'h1;

  typedef enum logic {
    IDLE  = 1'b0,
    BR_EX = 1'b1
  } br_state_t;

endpackage

// File: rtl/mips_hazard_ctrl_onehot_match.sv
// Masked AND-reduce of two one-hot register selects; r0 never produces a hit.
import mips_pkg::*;

module onehot_match #(
  parameter int N = NREG_DEF
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         hit
);

  localparam logic [N-1:0] W_MASK = {{(N-1){1'b1}}, 1'b0};

  assign hit = |(a & b & W_MASK);

endmodule

// File: rtl/mips_hazard_ctrl.sv
// Load-use stall and branch flush control for the five-stage MIPS pipeline,
// with a saturating stall-cycle counter for performance debug.
import mips_pkg::*;

module mips_hazard_ctrl #(
  parameter int NREG  = NREG_DEF,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_id,
  input  logic [NREG-1:0]  Aselect,
  input  logic [NREG-1:0]  Bselect,
  input  logic [NREG-1:0]  Dselect_id,
  input  logic             Imm_id,
  input  logic             LW_id,
  input  logic             SW_id,
  input  logic             BEQ_id,
  input  logic             BNE_id,
  input  logic             branch_taken,
  output logic             stall,
  output logic             flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [NREG-1:0]  dsel_mem,
  output logic             lw_mem
);

  logic [NREG-1:0]  r_dsel_ex;
  logic             r_lw_ex;
  logic [NREG-1:0]  r_dsel_mem;
  logic             r_lw_mem;
  br_state_t        r_br_state;
  logic [CNT_W-1:0] r_stall_cnt;

  logic             w_use_b;
  logic [NREG-1:0]  w_bsel;
  logic             w_hit_a;
  logic             w_hit_b;
  logic             w_hazard;
  logic             w_no_dest;
  logic             w_accept;

  // Immediate-form ALU ops ignore source B; stores and branches still read it.
  assign w_use_b   = ~Imm_id | SW_id | BEQ_id | BNE_id;
  assign w_bsel    = w_use_b ? Bselect : '0;
  assign w_no_dest = SW_id | BEQ_id | BNE_id;

  onehot_match #(.N(NREG)) u_match_a (
    .a   (r_dsel_ex),
    .b   (Aselect),
    .hit (w_hit_a)
  );

  onehot_match #(.N(NREG)) u_match_b (
    .a   (r_dsel_ex),
    .b   (w_bsel),
    .hit (w_hit_b)
  );

  assign w_hazard = valid_id & r_lw_ex & (w_hit_a | w_hit_b);
  assign flush    = (r_br_state == BR_EX) & branch_taken;
  assign stall    = w_hazard & ~flush;
  assign w_accept = valid_id & ~stall & ~flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_dsel_ex   <= '0;
      r_lw_ex     <= 1'b0;
      r_dsel_mem  <= '0;
      r_lw_mem    <= 1'b0;
      r_br_state  <= IDLE;
      r_stall_cnt <= '0;
    end else begin
      // A rejected or empty decode slot enters EX as a bubble.
      if (w_accept) begin
        r_dsel_ex <= Dselect_id & {NREG{~w_no_dest}};
        r_lw_ex   <= LW_id;
      end else begin
        r_dsel_ex <= '0;
        r_lw_ex   <= 1'b0;
      end
      r_dsel_mem <= r_dsel_ex;
      r_lw_mem   <= r_lw_ex;
      r_br_state <= (w_accept & (BEQ_id | BNE_id)) ? BR_EX : IDLE;
      if (stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign dsel_mem  = r_dsel_mem;
  assign lw_mem    = r_lw_mem;

endmodule

// File: tb/tb_mips_hazard_ctrl.sv
// Self-checking bench for mips_hazard_ctrl: per-cycle vector table with a
// scoreboard queue, hand sequences for flush/stall overlap, reset, saturation.
module tb_mips_hazard_ctrl;

  localparam logic [31:0] R0 = 32'h1;
  localparam logic [31:0] R5 = 32'h20;
  localparam logic [31:0] R6 = 32'h40;
  localparam logic [31:0] R7 = 32'h80;

  typedef struct {
    logic        rst, vld;
    logic [31:0] a, b, d;
    logic        imm, lw, sw, beq, bne, bt;
    logic        e_stall, e_flush;
    logic [15:0] e_cnt;
    logic [31:0] e_dsel;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, vld, imm, lw, sw, beq, bne, bt;
  logic [31:0] a, b, d;
  logic        stall, flush, lw_mem;
  logic [15:0] cnt;
  logic [31:0] dsel_mem;

  logic        s_vld, s_lw, s_imm;
  logic [31:0] s_a, s_d;
  logic        s_stall, s_flush, s_lw_mem;
  logic [3:0]  s_cnt;
  logic [31:0] s_dsel_mem;

  int n_vec = 0;
  int n_err = 0;

  vec_t tbl[$];
  vec_t exp_q[$];

  always #5 clk = ~clk;

  mips_hazard_ctrl #(.NREG(32), .CNT_W(16)) dut (
    .clk(clk), .reset(rst), .valid_id(vld),
    .Aselect(a), .Bselect(b), .Dselect_id(d),
    .Imm_id(imm), .LW_id(lw), .SW_id(sw), .BEQ_id(beq), .BNE_id(bne),
    .branch_taken(bt), .stall(stall), .flush(flush), .stall_cnt(cnt),
    .dsel_mem(dsel_mem), .lw_mem(lw_mem)
  );

  mips_hazard_ctrl #(.NREG(32), .CNT_W(4)) u_sat (
    .clk(clk), .reset(rst), .valid_id(s_vld),
    .Aselect(s_a), .Bselect(32'h0), .Dselect_id(s_d),
    .Imm_id(s_imm), .LW_id(s_lw), .SW_id(1'b0), .BEQ_id(1'b0), .BNE_id(1'b0),
    .branch_taken(1'b0), .stall(s_stall), .flush(s_flush), .stall_cnt(s_cnt),
    .dsel_mem(s_dsel_mem), .lw_mem(s_lw_mem)
  );

  function automatic vec_t mk(input logic r, v, input logic [31:0] ia, ib, id,
                              input logic im, l, s, bq, bn, t, es, ef,
                              input logic [15:0] ec, input logic [31:0] ed);
    vec_t x;
    x.rst = r; x.vld = v; x.a = ia; x.b = ib; x.d = id;
    x.imm = im; x.lw = l; x.sw = s; x.beq = bq; x.bne = bn; x.bt = t;
    x.e_stall = es; x.e_flush = ef; x.e_cnt = ec; x.e_dsel = ed;
    return x;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic drive(input vec_t v);
    rst = v.rst; vld = v.vld; a = v.a; b = v.b; d = v.d;
    imm = v.imm; lw = v.lw; sw = v.sw; beq = v.beq; bne = v.bne; bt = v.bt;
  endtask

  task automatic idle_inputs();
    drive(mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0));
  endtask

  initial begin
    vec_t e;
    idle_inputs();
    rst = 1'b1;
    s_vld = 0; s_lw = 0; s_imm = 0; s_a = 0; s_d = 0;
    repeat (2) @(posedge clk);

    //        rst vld a   b   d   imm lw sw beq bne bt  stall flush cnt dsel_ex
    tbl.push_back(mk(1,1,R6, 0, R5, 1,1,0,0,0,0, 0,0,0,0));
    tbl.push_back(mk(0,1,R6, 0, R5, 1,1,0,0,0,0, 0,0,0,0));
    tbl.push_back(mk(0,1,R5, R7,R7, 0,0,0,0,0,0, 1,0,0,R5));
    tbl.push_back(mk(0,1,R5, R7,R7, 0,0,0,0,0,0, 0,0,1,0));
    tbl.push_back(mk(0,1,R6, 0, R5, 1,1,0,0,0,0, 0,0,1,R7));
    tbl.push_back(mk(0,1,R6, R5,R7, 1,0,0,0,0,0, 0,0,1,R5));
    tbl.push_back(mk(0,1,R6, 0, R5, 1,1,0,0,0,0, 0,0,1,R7));
    tbl.push_back(mk(0,1,R6, R5,0,  1,0,1,0,0,0, 1,0,1,R5));
    tbl.push_back(mk(0,1,R6, R5,0,  1,0,1,0,0,0, 0,0,2,0));
    tbl.push_back(mk(0,1,R6, 0, R0, 1,1,0,0,0,0, 0,0,2,0));
    tbl.push_back(mk(0,1,R0, R0,R7, 0,0,0,0,0,0, 0,0,2,R0));
    tbl.push_back(mk(0,1,R6, R7,0,  0,0,0,1,0,0, 0,0,2,R7));
    tbl.push_back(mk(0,1,R6, 0, R7, 0,0,0,0,0,1, 0,1,2,0));
    tbl.push_back(mk(0,1,R6, R6,0,  0,0,0,0,1,1, 0,0,2,0));
    tbl.push_back(mk(0,1,R6, 0, R7, 0,0,0,0,0,0, 0,0,2,0));
    tbl.push_back(mk(0,1,R6, 0, R5, 1,1,0,0,0,0, 0,0,2,R7));
    tbl.push_back(mk(0,1,R5, R6,0,  0,0,0,1,0,0, 1,0,2,R5));
    tbl.push_back(mk(0,1,R5, R6,0,  0,0,0,1,0,1, 0,0,3,0));
    tbl.push_back(mk(0,1,R6, 0, R7, 0,0,0,0,0,1, 0,1,3,0));
    tbl.push_back(mk(0,0,0,  0, 0,  0,0,0,0,0,0, 0,0,3,0));

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i]);
      exp_q.push_back(tbl[i]);
      #1;
      e = exp_q.pop_front();
      check($sformatf("v%0d.stall", i), {31'b0, stall}, {31'b0, e.e_stall});
      check($sformatf("v%0d.flush", i), {31'b0, flush}, {31'b0, e.e_flush});
      check($sformatf("v%0d.cnt", i), {16'b0, cnt}, {16'b0, e.e_cnt});
      check($sformatf("v%0d.dsel_ex", i), dut.r_dsel_ex, e.e_dsel);
    end

    // Taken branch in EX while decode also sees a load-use hazard.
    @(negedge clk);
    drive(mk(0,1,R6,R7,0, 0,0,0,1,0,0, 0,0,0,0));
    @(negedge clk);
    force dut.r_dsel_ex = R5;
    force dut.r_lw_ex = 1'b1;
    drive(mk(0,1,R5,0,R7, 0,0,0,0,0,1, 0,0,0,0));
    #1;
    check("coinc.flush", {31'b0, flush}, 32'd1);
    check("coinc.stall", {31'b0, stall}, 32'd0);
    release dut.r_dsel_ex;
    release dut.r_lw_ex;
    @(negedge clk);
    idle_inputs();
    #1;
    check("coinc.cnt", {16'b0, cnt}, 32'd3);
    check("coinc.dsel_ex", dut.r_dsel_ex, 32'd0);

    // Reset asserted while stalling with a branch in EX.
    @(negedge clk);
    drive(mk(0,1,R6,R7,0, 0,0,0,0,1,0, 0,0,0,0));
    @(negedge clk);
    force dut.r_dsel_ex = R5;
    force dut.r_lw_ex = 1'b1;
    drive(mk(1,1,R5,0,R7, 0,0,0,0,0,0, 0,0,0,0));
    #1;
    check("rst.pre_stall", {31'b0, stall}, 32'd1);
    release dut.r_dsel_ex;
    release dut.r_lw_ex;
    @(negedge clk);
    drive(mk(0,1,R5,R5,R7, 0,0,0,0,0,1, 0,0,0,0));
    #1;
    check("rst.stall", {31'b0, stall}, 32'd0);
    check("rst.flush", {31'b0, flush}, 32'd0);
    check("rst.cnt", {16'b0, cnt}, 32'd0);
    check("rst.dsel_ex", dut.r_dsel_ex, 32'd0);
    check("rst.dsel_mem", dsel_mem, 32'd0);
    check("rst.lw_mem", {31'b0, lw_mem}, 32'd0);

    // Back-to-back dependent loads: a stall every other cycle on the 4-bit counter.
    @(negedge clk);
    idle_inputs();
    s_vld = 1; s_lw = 1; s_imm = 1; s_a = R5; s_d = R5;
    repeat (8) @(posedge clk);
    #1;
    check("sat.cnt_mid", {28'b0, s_cnt}, 32'd4);
    repeat (40) @(posedge clk);
    #1;
    check("sat.cnt_max", {28'b0, s_cnt}, 32'd15);
    repeat (6) @(posedge clk);
    #1;
    check("sat.cnt_hold", {28'b0, s_cnt}, 32'd15);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mips_hazard_ctrl.md
# mips_hazard_ctrl

Pipeline hazard controller for the five-stage MIPS datapath. It sits beside the decode stage and consumes the one-hot register selects and control flags that decode produces. It tracks the destinations of the instructions in EX and MEM, stalls decode on load-use hazards, and sequences branch resolution, flushing the wrong-path instruction when a BEQ/BNE is taken. A saturating counter records stall cycles for performance debug.

## Interface
- NREG, 32: register count; width of one-hot selects.
- CNT_W, 16: stall counter width.

- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- valid_id  in  1  decode holds a real instruction.
- Aselect  in  NREG  one-hot source A of decode instruction.
- Bselect  in  NREG  one-hot source B of decode instruction.
- Dselect_id  in  NREG  one-hot destination of decode instruction (after Imm mux).
- Imm_id, LW_id, SW_id, BEQ_id, BNE_id  in  1 each  decode control flags.
- branch_taken  in  1  EX-stage compare result; sampled only in state BR_EX.
- stall  out  1  hold PC and IF/ID; insert a bubble into EX.
- flush  out  1  kill the instruction in IF/ID; force a bubble into EX.
- stall_cnt  out  CNT_W  saturating count of cycles with stall=1.

## Operation
- Internal state:
  - dsel_ex, lw_ex: destination and load flag of the instruction in EX.
  - dsel_mem, lw_mem: same for MEM.
  - br_state in {IDLE, BR_EX}.
  - stall_cnt.
- useB = !Imm_id | SW_id | BEQ_id | BNE_id. Source B counts only when useB=1.
- hazard = valid_id & lw_ex & |((dsel_ex & (Aselect | (useB ? Bselect : 0))) & ~1). Bit 0 (r0) never hazards.
- flush = (br_state==BR_EX) & branch_taken.
- stall = hazard & ~flush. Flush has priority.
- EX tracking register update each cycle:
  - If stall or flush or !valid_id: dsel_ex <= 0, lw_ex <= 0 (bubble).
  - Otherwise: dsel_ex <= Dselect_id & {NREG{~SW_id & ~BEQ_id & ~BNE_id}}, lw_ex <= LW_id.
- MEM tracking: dsel_mem <= dsel_ex and lw_mem <= lw_ex unconditionally. The MEM copies exist only for the forwarding-unit port in a later revision; they do not drive stall.
- Branch FSM:
  - IDLE -> BR_EX when valid_id & (BEQ_id|BNE_id) & ~stall & ~flush.
  - BR_EX -> IDLE always, after one cycle. It re-enters BR_EX if a new branch is accepted in that same cycle and flush=0.
  - A branch killed by flush never enters BR_EX.
- stall_cnt increments when stall=1 and saturates at 2^CNT_W-1. It does not count flush cycles.

## Timing
- stall and flush are combinational from current inputs plus registered state, valid in the same cycle. There is no output register.
- Load-use penalty is exactly 1 cycle. After the bubble, lw_ex=0, so the held instruction proceeds the next cycle.
- Taken-branch penalty is 1 cycle: flush is asserted in the cycle after the branch left ID.
- Reset (synchronous, at any point, including mid-stall or in BR_EX): next cycle dsel_ex=dsel_mem=0, lw_ex=lw_mem=0, br_state=IDLE, stall_cnt=0. Hence stall=0 and flush=0 regardless of inputs, except a new hazard cannot exist because lw_ex=0.
- Simultaneous load-use and taken branch: flush=1, stall=0, the decode instruction is discarded, and stall_cnt is unchanged.
- A branch in ID during a stall waits; it enters BR_EX only in the cycle stall deasserts.

## Structure
- Shared package mips_pkg:
  - NREG_DEF=32.
  - br_state_t enum {IDLE, BR_EX}.
  - R0_MASK constant (~32'h1).
- Sub-module onehot_match(a, b, hit): masked AND-reduce of two one-hot vectors. It is instantiated twice (A path, B path); hazard ORs the two hits.

## Test plan
- LW writes r5 (Dselect_id=32'h20), then ADD with Aselect=32'h20: stall=1 for exactly 1 cycle, EX bubble (dsel_ex=0), stall_cnt 0->1, and the ADD proceeds next cycle.
- LW r5, then ADDI with Bselect=32'h20 and Imm_id=1: no stall, since B is unused. Same with SW using Bselect=32'h20: stall=1.
- LW to r0 (Dselect_id=32'h1) followed by a use of r0: stall=0.
- BEQ accepted, next cycle branch_taken=1: flush=1 for one cycle and br_state returns to IDLE. With branch_taken=0: flush=0.
- Taken flush coincident with a load-use hazard on the next instruction: flush=1, stall=0, stall_cnt unchanged.
- Assert reset while stall=1 and br_state=BR_EX: next cycle all tracking regs 0, stall=flush=0, stall_cnt=0. Separately, drive CNT_W=4 with continuous hazards: stall_cnt holds at 15.
